// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: 8N1 serial receiver with a one-entry holding register.
// RxD is synchronised through two flops. A start bit is confirmed at mid-bit,
// and every later bit is sampled one full bit period after the previous one.
// Status flags are sticky until the host pulses Read.
module uart_rx_sampler #(
  parameter int BitClocks = 10416,  // clock cycles per bit; even and >= 4
  parameter int CountBits = 14      // 2**CountBits must exceed BitClocks
) (
  input  logic       Clock,
  input  logic       MR,
  input  logic       RxD,
  input  logic       Read,
  output logic [7:0] RxData,
  output logic       DataValid,
  output logic       FramingError,
  output logic       Overrun,
  output logic       Busy
);

  // Counter value at the middle of the start bit, and at the end of a full bit.
  localparam logic [CountBits-1:0] HalfLast = CountBits'(BitClocks / 2 - 1);
  localparam logic [CountBits-1:0] BitLast  = CountBits'(BitClocks - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAITHIGH
  } state_t;

  state_t               state_q;
  logic                 rx_meta_q;
  logic                 rxs_q;
  logic [CountBits-1:0] cnt_q;
  logic [CountBits-1:0] cnt_d;
  logic [2:0]           bit_idx_q;
  logic [7:0]           shift_q;
  logic [7:0]           rx_data_q;
  logic                 data_valid_q;
  logic                 framing_error_q;
  logic                 overrun_q;
  logic                 busy_q;

  assign cnt_d = cnt_q + CountBits'(1);

  // Two-flop synchroniser for the asynchronous serial line; idles high.
  always_ff @(posedge Clock or posedge MR) begin
    if (MR) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= RxD;
      rxs_q     <= rx_meta_q;
    end
  end

  // Frame recovery FSM, holding register, and status flags.
  always_ff @(posedge Clock or posedge MR) begin
    if (MR) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      bit_idx_q       <= 3'd0;
      shift_q         <= 8'h00;
      rx_data_q       <= 8'h00;
      data_valid_q    <= 1'b0;
      framing_error_q <= 1'b0;
      overrun_q       <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      // Busy is a registered decode of the current state.
      busy_q <= (state_q != S_IDLE);

      // A host read clears the status. The accept and framing-error
      // assignments below come later, so they win in the same cycle.
      if (Read) begin
        data_valid_q    <= 1'b0;
        framing_error_q <= 1'b0;
        overrun_q       <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (!rxs_q) begin
            state_q <= S_START;
            cnt_q   <= '0;
          end
        end

        S_START: begin
          if (cnt_q == HalfLast) begin
            if (!rxs_q) begin
              state_q   <= S_DATA;
              cnt_q     <= '0;
              bit_idx_q <= 3'd0;
            end else begin
              // The line went high again before mid-bit: this was a glitch.
              state_q <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end

        S_DATA: begin
          if (cnt_q == BitLast) begin
            // Data arrives LSB first, so shift right and insert at the MSB.
            shift_q <= {rxs_q, shift_q[7:1]};
            cnt_q   <= '0;
            if (bit_idx_q == 3'd7) begin
              state_q <= S_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end

        S_STOP: begin
          if (cnt_q == BitLast) begin
            cnt_q <= '0;
            if (rxs_q) begin
              state_q <= S_IDLE;
              if (!data_valid_q || Read) begin
                rx_data_q    <= shift_q;
                data_valid_q <= 1'b1;
              end else begin
                // The unread byte is kept and the new byte is dropped.
                overrun_q <= 1'b1;
              end
            end else begin
              framing_error_q <= 1'b1;
              state_q         <= S_WAITHIGH;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end

        S_WAITHIGH: begin
          // Hold here through a break so it reports only one framing error.
          if (rxs_q) begin
            state_q <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign RxData       = rx_data_q;
  assign DataValid    = data_valid_q;
  assign FramingError = framing_error_q;
  assign Overrun      = overrun_q;
  assign Busy         = busy_q;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb_uart_rx_sampler: directed frames checked every cycle against a
// frame-level reference model, plus hand-computed literal expectations.
module tb_uart_rx_sampler;

  localparam int BC = 16;
  localparam int CB = 5;

  logic       Clock = 1'b0;
  logic       MR;
  logic       RxD;
  logic       Read;
  logic [7:0] RxData;
  logic       DataValid;
  logic       FramingError;
  logic       Overrun;
  logic       Busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int dv_rise_cyc;
  int busy_fall_cyc;
  int start_cyc;
  logic dv_prev = 1'b0;
  logic busy_prev = 1'b0;

  uart_rx_sampler #(.BitClocks(BC), .CountBits(CB)) dut (
    .Clock       (Clock),
    .MR          (MR),
    .RxD         (RxD),
    .Read        (Read),
    .RxData      (RxData),
    .DataValid   (DataValid),
    .FramingError(FramingError),
    .Overrun     (Overrun),
    .Busy        (Busy)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  // Reference model. It tracks the age of a frame in clock edges since the
  // start was detected. The start is confirmed at age BC/2, and bit k
  // (1..8 = data, 9 = stop) is taken at age BC/2 + k*BC.
  int         m_mode;  // 0 idle, 1 in frame, 2 waiting for the line to go high
  int         m_age;
  logic [7:0] m_byte;
  logic       m_s1, m_s2;
  logic [7:0] m_data;
  logic       m_dv, m_fe, m_ov, m_busy;

  always @(posedge Clock or posedge MR) begin : model_step
    logic rxs;
    logic acc;
    logic ferr;
    int   k;
    if (MR) begin
      m_mode = 0; m_age = 0; m_byte = 8'h00;
      m_s1 = 1'b1; m_s2 = 1'b1;
      m_data = 8'h00; m_dv = 1'b0; m_fe = 1'b0; m_ov = 1'b0; m_busy = 1'b0;
    end else begin
      rxs  = m_s2;
      acc  = 1'b0;
      ferr = 1'b0;
      m_busy = (m_mode != 0);
      case (m_mode)
        0: if (!rxs) begin m_mode = 1; m_age = 0; end
        1: begin
          m_age = m_age + 1;
          if (m_age == BC / 2) begin
            if (rxs) m_mode = 0;
          end else if (m_age > BC / 2 && ((m_age - BC / 2) % BC) == 0) begin
            k = (m_age - BC / 2) / BC;
            if (k <= 8) m_byte[k-1] = rxs;
            else if (rxs) begin acc = 1'b1; m_mode = 0; end
            else begin ferr = 1'b1; m_mode = 2; end
          end
        end
        default: if (rxs) m_mode = 0;
      endcase
      if (acc) begin
        if (!m_dv || Read) begin
          m_data = m_byte;
          m_dv = 1'b1;
        end else begin
          m_dv = Read ? 1'b0 : m_dv;
          m_ov = 1'b1;
        end
        if (Read) m_ov = 1'b0;
        if (Read) m_fe = 1'b0;
      end else if (Read) begin
        m_dv = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
      end
      if (ferr) m_fe = 1'b1;
      m_s2 = m_s1;
      m_s1 = RxD;
    end
  end

  // Every-cycle comparison plus edge monitors for latency measurements.
  always @(negedge Clock) begin
    checks++;
    if ({RxData, DataValid, FramingError, Overrun, Busy} !==
        {m_data, m_dv, m_fe, m_ov, m_busy}) begin
      errors++;
      $display("FAIL model cycle %0d: got data=%h dv=%b fe=%b ov=%b busy=%b want data=%h dv=%b fe=%b ov=%b busy=%b",
               cyc, RxData, DataValid, FramingError, Overrun, Busy,
               m_data, m_dv, m_fe, m_ov, m_busy);
    end
    if (DataValid && !dv_prev) dv_rise_cyc = cyc;
    if (!Busy && busy_prev) busy_fall_cyc = cyc;
    dv_prev   = DataValid;
    busy_prev = Busy;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h want=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle_bits(input int nbits);
    RxD = 1'b1;
    repeat (nbits * BC) tick();
  endtask

  task automatic read_pulse();
    Read = 1'b1;
    tick();
    Read = 1'b0;
  endtask

  // Drives start, 8 data bits LSB first, then nstop bit-times of stopv.
  // Read is pulsed on loop index rd (use -1 for none); maxcyc truncates.
  task automatic frame(input logic [7:0] d, input logic stopv, input int nstop,
                       input int rd, input int maxcyc);
    $display("frame data=%h stop=%b x%0d read_at=%0d limit=%0d", d, stopv, nstop, rd, maxcyc);
    for (int i = 0; i < (9 + nstop) * BC && i < maxcyc; i++) begin
      int j;
      j = i / BC;
      RxD  = (j == 0) ? 1'b0 : ((j <= 8) ? d[j-1] : stopv);
      Read = (i == rd);
      tick();
    end
    Read = 1'b0;
  endtask

  initial begin
    MR = 1'b1; RxD = 1'b1; Read = 1'b0;
    repeat (3) tick();
    chk("reset_data", RxData, 8'h00);
    chk("reset_flags", {DataValid, FramingError, Overrun, Busy}, 4'b0000);
    MR = 1'b0;
    idle_bits(2);

    // 0xA5 with latency and Busy-lag measurement.
    dv_rise_cyc = -1; busy_fall_cyc = -1; start_cyc = cyc + 1;
    frame(8'hA5, 1'b1, 1, -1, 100000);
    idle_bits(1);
    chk("a5_data", RxData, 8'hA5);
    chk("a5_valid_fe", {DataValid, FramingError}, 2'b10);
    chk("a5_latency", dv_rise_cyc - start_cyc, 2 + 8 + 16 * 9);
    chk("a5_busy_lag", busy_fall_cyc - dv_rise_cyc, 1);

    // Read, then two back-to-back frames.
    read_pulse();
    chk("read_clears_dv", DataValid, 1'b0);
    chk("read_keeps_data", RxData, 8'hA5);
    frame(8'h00, 1'b1, 1, -1, 100000);
    chk("b2b_first", {RxData, DataValid}, {8'h00, 1'b1});
    frame(8'hFF, 1'b1, 1, 5, 100000);
    idle_bits(1);
    chk("b2b_second", {RxData, DataValid, Overrun}, {8'hFF, 1'b1, 1'b0});

    // Break: stop held low for 40 bit times.
    read_pulse();
    frame(8'h3C, 1'b0, 40, -1, 100000);
    chk("break_busy", Busy, 1'b1);
    chk("break_fe_dv", {FramingError, DataValid}, 2'b10);
    idle_bits(2);
    chk("break_release_busy", Busy, 1'b0);
    frame(8'h81, 1'b1, 1, -1, 100000);
    idle_bits(1);
    chk("after_break", {RxData, DataValid}, {8'h81, 1'b1});

    // Overrun, then accept with a simultaneous Read.
    read_pulse();
    chk("cleared", {DataValid, FramingError, Overrun}, 3'b000);
    frame(8'h11, 1'b1, 1, -1, 100000);
    frame(8'h22, 1'b1, 1, -1, 100000);
    idle_bits(1);
    chk("overrun", {RxData, DataValid, Overrun}, {8'h11, 1'b1, 1'b1});
    read_pulse();
    chk("overrun_read", {DataValid, Overrun}, 2'b00);
    frame(8'h11, 1'b1, 1, -1, 100000);
    frame(8'h22, 1'b1, 1, 154, 100000);
    idle_bits(1);
    chk("read_at_accept", {RxData, DataValid, Overrun}, {8'h22, 1'b1, 1'b0});

    // Short low glitch on an idle line.
    read_pulse();
    RxD = 1'b0;
    repeat (3) tick();
    idle_bits(2);
    chk("glitch", {DataValid, FramingError, Overrun, Busy}, 4'b0000);

    // Reset during data bit 4.
    frame(8'h66, 1'b1, 1, -1, 100000);
    idle_bits(1);
    frame(8'h77, 1'b1, 1, -1, 5 * BC + 8);
    chk("pre_reset_busy", Busy, 1'b1);
    MR = 1'b1;
    #1;
    chk("mr_data", RxData, 8'h00);
    chk("mr_flags", {DataValid, FramingError, Overrun, Busy}, 4'b0000);
    tick();
    tick();
    RxD = 1'b1;
    MR = 1'b0;
    idle_bits(2);
    frame(8'h5A, 1'b1, 1, -1, 100000);
    idle_bits(1);
    chk("post_reset_frame", {RxData, DataValid, FramingError, Overrun}, {8'h5A, 3'b100});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
